dm_arbiter: RTL

Two-port arbiter and access sequencer for the SISC single-port data memory (dm). It shares dm between the processor core (port 0, driven by the ctrl/alu load-store path) and an external loader/debug port (port 1). Each access is run through a fixed three-state sequence: arbitrate, drive memory, return response. Round-robin arbitration resolves contention so that neither port starves.

---
 rtl/dm_arbiter_if.sv | 35 +++
 rtl/dm_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the dm bus around dm_arbiter.
// The master side is the requesters plus memory; the slave side is the arbiter.
interface dm_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_we;
    logic [DW-1:0] dm_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_rdata,
        input  gnt0, gnt1, done0, done1, rdata, busy, dm_addr, dm_wdata, dm_we
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_rdata,
        output gnt0, gnt1, done0, done1, rdata, busy, dm_addr, dm_wdata, dm_we
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter and three-step access sequencer sharing the single-port
// data memory between the core (port 0) and the loader/debug port (port 1).
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | sample requests, latch the winner's payload
//   ST_ACCESS | winner's gnt high, latched access driven onto dm
//   ST_RESP   | winner's done high, rdata valid for reads
module dm_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst_f,
    dm_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          win;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        // On a tie the port that did not win last time gets the bus.
        win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = ST_ACCESS;
                    sel_d   = win;
                    last_d  = win;
                    we_d    = win ? bus.we1    : bus.we0;
                    addr_d  = win ? bus.addr1  : bus.addr0;
                    wdata_d = win ? bus.wdata1 : bus.wdata0;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d = bus.dm_rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACCESS) || (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    // dm address/data always come from the latched payload, so requester
    // changes after sampling never reach the memory.
    assign bus.gnt0     = (state_q == ST_ACCESS) && !sel_q;
    assign bus.gnt1     = (state_q == ST_ACCESS) &&  sel_q;
    assign bus.done0    = (state_q == ST_RESP)   && !sel_q;
    assign bus.done1    = (state_q == ST_RESP)   &&  sel_q;
    assign bus.dm_we    = (state_q == ST_ACCESS) &&  we_q;
    assign bus.dm_addr  = addr_q;
    assign bus.dm_wdata = wdata_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
endmodule
